// File: rtl/id_ctrl.sv
// ----------------------------------------------------------------------------
// id_ctrl : decode-stage controller for a short in-order pipeline.
//
// Holds one instruction from fetch, decodes its source-register usage and
// immediate format, and issues it to execute. A load in execute whose
// destination feeds a used source of the held instruction inserts exactly
// one bubble cycle (STALL). A flush drops the held instruction and anything
// offered by fetch in the same cycle.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   if_valid   : fetch offers if_ir
//   if_ir      : offered instruction word
//   id_ready   : decode accepts if_ir this cycle
//   ex_valid   : held instruction is issued to execute this cycle
//   ex_ready   : execute accepts the issued instruction
//   ex_rd      : destination register of the instruction in execute
//   ex_is_load : instruction in execute is a load
//   flush      : discard the held instruction (branch redirect)
//   id_ir      : held instruction word
//   imm_sel    : immediate format of id_ir (0 none, 1 I, 2 S, 3 U)
//   illegal    : held opcode is not one this pipeline implements
//   stall_cnt  : saturating count of load-use bubble cycles
// ----------------------------------------------------------------------------
module id_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_ir,
  output logic             id_ready,
  output logic             ex_valid,
  input  logic             ex_ready,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             flush,
  output logic [31:0]      id_ir,
  output logic [1:0]       imm_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  state_t     state;
  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       hazard;

  assign opcode = id_ir[6:0];
  assign rs1    = id_ir[19:15];
  assign rs2    = id_ir[24:20];

  // Source usage and immediate format straight from the held opcode.
  // Unknown opcodes read no registers, so they can never cause a stall.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    imm_sel  = 2'd0;
    illegal  = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD: begin
        rs1_used = 1'b1;
        imm_sel  = 2'd1;
      end
      OP_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm_sel  = 2'd2;
      end
      OP_LUI: begin
        imm_sel  = 2'd3;
      end
      OP_REG: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: begin
        illegal  = 1'b1;
      end
    endcase
  end

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

  // Handshakes. ex_valid is also masked by rst so that an instruction caught
  // in HOLD when reset arrives is never seen by execute.
  always_comb begin
    id_ready = 1'b0;
    ex_valid = 1'b0;
    case (state)
      EMPTY: id_ready = 1'b1;
      HOLD: begin
        id_ready = ex_ready && !hazard && !flush;
        ex_valid = !hazard && !flush && !rst;
      end
      default: begin
        id_ready = 1'b0;
        ex_valid = 1'b0;
      end
    endcase
  end

  // State, held instruction and bubble counter. HOLD with ex_ready and a new
  // offer reloads id_ir in place so a stream issues with no bubbles. The
  // counter keeps its value across flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      id_ir     <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state == STALL) && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        EMPTY: begin
          if (if_valid && !flush) begin
            id_ir <= if_ir;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (flush) begin
            state <= EMPTY;
          end else if (hazard) begin
            state <= STALL;
          end else if (ex_ready && if_valid) begin
            id_ir <= if_ir;
          end else if (ex_ready) begin
            state <= EMPTY;
          end
        end
        STALL: begin
          state <= flush ? EMPTY : HOLD;
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
// ----------------------------------------------------------------------------
// tb_id_ctrl : self-checking bench for id_ctrl (built with CNT_W = 4).
//
// Directed vectors are driven on the falling edge. Every instruction that is
// expected to reach execute has its expected decode pushed into a queue when
// it is offered; an independent monitor pops and compares on every issue
// (ex_valid && ex_ready). Cycle-level handshake and counter values are
// checked directly by the stimulus process.
// ----------------------------------------------------------------------------
module tb_id_ctrl;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] ir;
    logic [1:0]  imm;
    logic        ill;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             if_valid;
  logic [31:0]      if_ir;
  logic             id_ready;
  logic             ex_valid;
  logic             ex_ready;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             flush;
  logic [31:0]      id_ir;
  logic [1:0]       imm_sel;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nFailed   = 0;

  id_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_ir     (if_ir),
    .id_ready  (id_ready),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rd     (ex_rd),
    .ex_is_load(ex_is_load),
    .flush     (flush),
    .id_ir     (id_ir),
    .imm_sel   (imm_sel),
    .illegal   (illegal),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of inputs, applied on the falling edge and settled 1 unit later.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ir,
                               input logic er, input logic [4:0] rd,
                               input logic ld, input logic fl);
    @(negedge clk);
    rst        = r;
    if_valid   = v;
    if_ir      = ir;
    ex_ready   = er;
    ex_rd      = rd;
    ex_is_load = ld;
    flush      = fl;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectIssue(input logic [31:0] ir, input logic [1:0] imm, input logic ill);
    exp_t e;
    e.ir  = ir;
    e.imm = imm;
    e.ill = ill;
    expQ.push_back(e);
  endtask

  // Issue monitor: runs after the stimulus checks, before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nFailed++;
          $display("[TB] FAIL unexpected_issue: got id_ir %h, expected no issue at %0t", id_ir, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue_ir", id_ir, e.ir);
          checkOutput("issue_imm_sel", 32'(imm_sel), 32'(e.imm));
          checkOutput("issue_illegal", 32'(illegal), 32'(e.ill));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_ir = '0; ex_ready = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; flush = 1'b0;
    $display("[TB] start");

    // Reset: second reset cycle also offers an instruction that must be ignored.
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'hDEADBEEF, 1, 0, 0, 0);
    checkOutput("rst_id_ready", 32'(id_ready), 32'd1);
    checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_imm_sel", 32'(imm_sel), 32'd0);
    checkOutput("rst_id_ir", id_ir, 32'h0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Back-to-back addi stream; a load to x5 must not stall addi (rs2 unused).
    expectIssue(32'h00500093, 2'd1, 1'b0);
    applyStimulus(0, 1, 32'h00500093, 1, 0, 0, 0);
    checkOutput("s0_id_ready", 32'(id_ready), 32'd1);
    checkOutput("s0_ex_valid", 32'(ex_valid), 32'd0);
    expectIssue(32'h00208113, 2'd1, 1'b0);
    applyStimulus(0, 1, 32'h00208113, 1, 5'd5, 1, 0);
    checkOutput("s1_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("s1_id_ready", 32'(id_ready), 32'd1);
    checkOutput("s1_id_ir", id_ir, 32'h00500093);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("s2_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("s2_id_ir", id_ir, 32'h00208113);

    // sw x2,0(x1) behind a load to x2: one bubble, counter 0 -> 1.
    expectIssue(32'h0020A023, 2'd2, 1'b0);
    applyStimulus(0, 1, 32'h0020A023, 1, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 5'd2, 1, 0);
    checkOutput("lu_hold_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu_hold_id_ready", 32'(id_ready), 32'd0);
    checkOutput("lu_hold_stall_cnt", 32'(stall_cnt), 32'd0);
    applyStimulus(0, 1, 32'hDEADBEEF, 1, 0, 0, 0);
    checkOutput("lu_stall_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu_stall_id_ready", 32'(id_ready), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("lu_issue_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("lu_issue_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("lu_issue_id_ir", id_ir, 32'h0020A023);

    // Same store, load targets x0: no bubble, counter untouched.
    expectIssue(32'h0020A023, 2'd2, 1'b0);
    applyStimulus(0, 1, 32'h0020A023, 1, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 5'd0, 1, 0);
    checkOutput("x0_ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("x0_id_ready", 32'(id_ready), 32'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
    checkOutput("x0_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("x0_empty_ex_valid", 32'(ex_valid), 32'd0);

    // lui under backpressure; load to x8 matches its unused rs1 field.
    expectIssue(32'h123450B7, 2'd3, 1'b0);
    applyStimulus(0, 1, 32'h123450B7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'hDEADBEEF, 0, 5'd8, 1, 0);
      checkOutput("bp_ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("bp_id_ready", 32'(id_ready), 32'd0);
      checkOutput("bp_id_ir", id_ir, 32'h123450B7);
      checkOutput("bp_imm_sel", 32'(imm_sel), 32'd3);
    end
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("bp_release_ex_valid", 32'(ex_valid), 32'd1);

    // Illegal opcode is held and issued normally.
    expectIssue(32'h0000007F, 2'd0, 1'b1);
    applyStimulus(0, 1, 32'h0000007F, 1, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("ill_illegal", 32'(illegal), 32'd1);
    checkOutput("ill_imm_sel", 32'(imm_sel), 32'd0);
    checkOutput("ill_ex_valid", 32'(ex_valid), 32'd1);

    // Flush during STALL with an offer: nothing issues, offer dropped.
    applyStimulus(0, 1, 32'h00208113, 1, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 5'd1, 1, 0);
    checkOutput("fl_hazard_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(0, 1, 32'h00500093, 1, 0, 0, 1);
    checkOutput("fl_stall_id_ready", 32'(id_ready), 32'd0);
    checkOutput("fl_stall_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(0, 1, 32'h00500093, 1, 0, 0, 1);
    checkOutput("fl_empty_id_ready", 32'(id_ready), 32'd1);
    checkOutput("fl_empty_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("fl_after_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("fl_after_id_ir", id_ir, 32'h00208113);
    checkOutput("fl_after_stall_cnt", 32'(stall_cnt), 32'd2);

    // Flush in HOLD with an offer.
    applyStimulus(0, 1, 32'h0020A023, 1, 0, 0, 0);
    applyStimulus(0, 1, 32'h00500093, 1, 0, 0, 1);
    checkOutput("flh_id_ready", 32'(id_ready), 32'd0);
    checkOutput("flh_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("flh_after_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("flh_after_id_ir", id_ir, 32'h0020A023);

    // 18 bubbles from a persistent rs1 hazard: counter 2 saturates at 0xF.
    expectIssue(32'h00208113, 2'd1, 1'b0);
    applyStimulus(0, 1, 32'h00208113, 1, 0, 0, 0);
    for (int i = 0; i < 36; i++) begin
      applyStimulus(0, 0, 32'h0, 1, 5'd1, 1, 0);
    end
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'hF);
    checkOutput("sat_ex_valid", 32'(ex_valid), 32'd1);

    // Reset in STALL: no issue, counter and id_ir cleared.
    applyStimulus(0, 1, 32'h00208113, 1, 0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 5'd1, 1, 0);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("rs_stall_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("rs_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rs_stall_id_ir", id_ir, 32'h0);
    checkOutput("rs_stall_id_ready", 32'(id_ready), 32'd1);

    // Reset in HOLD while execute is ready: still no issue.
    applyStimulus(0, 1, 32'h0020A023, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("rh_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 0);
    checkOutput("rh_id_ir", id_ir, 32'h0);
    checkOutput("rh_after_ex_valid", 32'(ex_valid), 32'd0);

    applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
    checkOutput("pending_issues", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
